// File: rtl/pipeline_mem_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one single-port memory, with an ack timeout.
// Optional macro MEM_ARB_RR_EN: round-robin on ties instead of fixed data-first priority.
module pipeline_mem_arbiter #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, IF_WAIT, DM_WAIT} state_t;

  state_t     state;
  logic [7:0] wait_cnt;
  logic       in_wait;
  logic       timeout;
  logic       grant_if;
  logic       grant_dm;

  assign in_wait = (state == IF_WAIT) || (state == DM_WAIT);
  assign timeout = in_wait && !mem_ack && (wait_cnt == 8'(MAX_WAIT));

`ifdef MEM_ARB_RR_EN
  logic last_if;

  // On a tie the requester that was not granted last time goes next.
  assign grant_dm = dm_req && (!if_req || last_if);
`else
  logic last_unused;

  assign last_unused = 1'b0;
  assign grant_dm = dm_req;
`endif
  assign grant_if = if_req && !grant_dm;

  assign if_done  = (state == IF_WAIT) && (mem_ack || timeout);
  assign dm_done  = (state == DM_WAIT) && (mem_ack || timeout);
  assign if_rdata = ((state == IF_WAIT) && mem_ack) ? mem_rdata : 32'h0;
  assign dm_rdata = ((state == DM_WAIT) && mem_ack) ? mem_rdata : 32'h0;
  assign stall    = !rst && ((if_req && !if_done) || (dm_req && !dm_done));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      wait_cnt  <= 8'h0;
      err       <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_if   <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_dm) begin
            state     <= DM_WAIT;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            wait_cnt  <= 8'h0;
`ifdef MEM_ARB_RR_EN
            last_if   <= 1'b0;
`endif
          end else if (grant_if) begin
            state     <= IF_WAIT;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= 32'h0;
            wait_cnt  <= 8'h0;
`ifdef MEM_ARB_RR_EN
            last_if   <= 1'b1;
`endif
          end
        end
        IF_WAIT, DM_WAIT: begin
          // An ack arriving together with the timeout completes normally.
          if (mem_ack || timeout) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (timeout) err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Self-checking bench: a transaction-level arbiter model checked every cycle, plus directed literal checks.
module tb_pipeline_mem_arbiter;

  localparam int MAX_WAIT_TB = 3;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        err;

  int          checks = 0;
  int          failures = 0;

  int          ack_after = 0;
  logic [31:0] rd_value = 32'h0;
  bit          force_ack = 1'b0;
  int          req_cnt = 0;
  bit          prev_req = 1'b0;

  pipeline_mem_arbiter #(.MAX_WAIT(MAX_WAIT_TB)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                               input logic dwe, input logic [31:0] daddr, input logic [31:0] dwdata);
    if_req   = ireq;
    if_addr  = iaddr;
    dm_req   = dreq;
    dm_we    = dwe;
    dm_addr  = daddr;
    dm_wdata = dwdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: acks on the Nth consecutive cycle mem_req is high (negative = never).
  always @(posedge clk) begin
    #2;
    if (mem_req) req_cnt = prev_req ? req_cnt + 1 : 0;
    prev_req  = mem_req;
    mem_ack   = force_ack || (mem_req && ack_after >= 0 && req_cnt == ack_after);
    mem_rdata = rd_value;
  end

  // Transaction model: one access in flight, judged by who owns it and how long it has waited.
  bit          m_busy, m_dm, m_we, m_err, m_last_if, finish, abort, pick_dm;
  logic [31:0] m_addr, m_wdata;
  int          m_waited;
  logic        e_if_done, e_dm_done, e_stall;
  logic [31:0] e_if_rdata, e_dm_rdata;

  always @(negedge clk) begin
    if (rst) begin
      m_busy = 0; m_dm = 0; m_we = 0; m_err = 0; m_last_if = 1;
      m_addr = 0; m_wdata = 0; m_waited = 0;
      checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
      checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
      checkOutput("rst_mem_addr", mem_addr, 32'd0);
      checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_stall", 32'(stall), 32'd0);
      checkOutput("rst_if_done", 32'(if_done), 32'd0);
      checkOutput("rst_dm_done", 32'(dm_done), 32'd0);
    end else begin
      e_if_done = 0; e_dm_done = 0; e_if_rdata = 0; e_dm_rdata = 0;
      finish = 0; abort = 0;
      if (m_busy) begin
        if (mem_ack) finish = 1;
        else if (m_waited >= MAX_WAIT_TB) begin finish = 1; abort = 1; end
        if (finish && m_dm) begin
          e_dm_done = 1; e_dm_rdata = abort ? 32'h0 : mem_rdata;
        end else if (finish) begin
          e_if_done = 1; e_if_rdata = abort ? 32'h0 : mem_rdata;
        end
      end
      e_stall = (if_req && !e_if_done) || (dm_req && !e_dm_done);
      checkOutput("mem_req", 32'(mem_req), 32'(m_busy));
      if (m_busy) begin
        checkOutput("mem_we", 32'(mem_we), 32'(m_we));
        checkOutput("mem_addr", mem_addr, m_addr);
        checkOutput("mem_wdata", mem_wdata, m_wdata);
      end
      checkOutput("if_done", 32'(if_done), 32'(e_if_done));
      checkOutput("dm_done", 32'(dm_done), 32'(e_dm_done));
      checkOutput("if_rdata", if_rdata, e_if_rdata);
      checkOutput("dm_rdata", dm_rdata, e_dm_rdata);
      checkOutput("stall", 32'(stall), 32'(e_stall));
      checkOutput("err", 32'(err), 32'(m_err));
      if (m_busy) begin
        if (finish) begin
          m_busy = 0;
          if (abort) m_err = 1;
        end else m_waited++;
      end else if (if_req || dm_req) begin
`ifdef MEM_ARB_RR_EN
        pick_dm = dm_req && (!if_req || m_last_if);
`else
        pick_dm = dm_req;
`endif
        m_busy = 1; m_dm = pick_dm; m_waited = 0; m_last_if = !pick_dm;
        m_we    = pick_dm ? dm_we : 1'b0;
        m_addr  = pick_dm ? dm_addr : if_addr;
        m_wdata = pick_dm ? dm_wdata : 32'h0;
      end
    end
  end

  logic [3:0] order;
  logic [3:0] exp_order;

  initial begin
    rst = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick(); tick();
    @(negedge clk);
    checkOutput("lit_reset_mem_req", 32'(mem_req), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Fetch with ack on the second wait cycle
    rd_value = 32'h00A00093; ack_after = 1;
    applyStimulus(1, 32'h10, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("lit_if_c0_stall", 32'(stall), 32'd1);
    checkOutput("lit_if_c0_mem_req", 32'(mem_req), 32'd0);
    tick(); @(negedge clk);
    checkOutput("lit_if_c1_mem_req", 32'(mem_req), 32'd1);
    checkOutput("lit_if_c1_mem_addr", mem_addr, 32'h10);
    checkOutput("lit_if_c1_done", 32'(if_done), 32'd0);
    checkOutput("lit_if_c1_stall", 32'(stall), 32'd1);
    tick(); @(negedge clk);
    checkOutput("lit_if_c2_done", 32'(if_done), 32'd1);
    checkOutput("lit_if_c2_rdata", if_rdata, 32'h00A00093);
    checkOutput("lit_if_c2_stall", 32'(stall), 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("lit_if_c3_mem_req", 32'(mem_req), 32'd0);

    // Store with immediate ack
    tick();
    rd_value = 32'h12345678; ack_after = 0;
    applyStimulus(0, 0, 1, 1, 32'h20, 32'hDEADBEEF);
    tick(); @(negedge clk);
    checkOutput("lit_st_mem_we", 32'(mem_we), 32'd1);
    checkOutput("lit_st_mem_addr", mem_addr, 32'h20);
    checkOutput("lit_st_mem_wdata", mem_wdata, 32'hDEADBEEF);
    checkOutput("lit_st_dm_done", 32'(dm_done), 32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Both requesters held for four accesses, from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_value = 32'hCAFE0000; ack_after = 0;
    applyStimulus(1, 32'h40, 1, 0, 32'h80, 32'h11);
    order = 4'b0;
    for (int k = 0; k < 4; k++) begin
      tick(); @(negedge clk);
      order[k] = dm_done;
      checkOutput("lit_tie_one_done", 32'(if_done ^ dm_done), 32'd1);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
`ifdef MEM_ARB_RR_EN
    exp_order = 4'b0101;
`else
    exp_order = 4'b1111;
`endif
    checkOutput("lit_tie_order", 32'(order), 32'(exp_order));

    // Ack on the very cycle the wait count hits the limit: normal completion
    tick();
    ack_after = 3; rd_value = 32'h0BADF00D;
    applyStimulus(0, 0, 1, 0, 32'h44, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); @(negedge clk);
      checkOutput("lit_edge_no_done", 32'(dm_done), 32'd0);
    end
    tick(); @(negedge clk);
    checkOutput("lit_edge_done", 32'(dm_done), 32'd1);
    checkOutput("lit_edge_rdata", dm_rdata, 32'h0BADF00D);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("lit_edge_err", 32'(err), 32'd0);

    // No ack at all: abort after the limit, sticky error
    tick();
    ack_after = -1; rd_value = 32'hFFFFFFFF;
    applyStimulus(0, 0, 1, 0, 32'h48, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); @(negedge clk);
      checkOutput("lit_to_no_done", 32'(dm_done), 32'd0);
    end
    tick(); @(negedge clk);
    checkOutput("lit_to_done", 32'(dm_done), 32'd1);
    checkOutput("lit_to_rdata", dm_rdata, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("lit_to_err", 32'(err), 32'd1);
    repeat (3) tick();
    @(negedge clk);
    checkOutput("lit_to_err_sticky", 32'(err), 32'd1);

    // Reset in the middle of a data wait, with a stray ack during reset
    tick();
    applyStimulus(0, 0, 1, 0, 32'h4C, 0);
    tick(); @(negedge clk);
    checkOutput("lit_mid_mem_req", 32'(mem_req), 32'd1);
    #1;
    rst = 1'b1; force_ack = 1'b1;
    #1;
    checkOutput("lit_async_mem_req", 32'(mem_req), 32'd0);
    checkOutput("lit_async_dm_done", 32'(dm_done), 32'd0);
    checkOutput("lit_async_err", 32'(err), 32'd0);
    tick();
    applyStimulus(1, 32'h50, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("lit_rst_ack_ignored", 32'(mem_req | if_done | dm_done), 32'd0);
    tick();
    rst = 1'b0; force_ack = 1'b0; ack_after = 0; rd_value = 32'h00000013;
    tick(); @(negedge clk);
    checkOutput("lit_post_mem_addr", mem_addr, 32'h50);
    checkOutput("lit_post_mem_we", 32'(mem_we), 32'd0);
    checkOutput("lit_post_if_done", 32'(if_done), 32'd1);
    checkOutput("lit_post_if_rdata", if_rdata, 32'h00000013);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_mem_arbiter.md
PIPELINE_MEM_ARBITER -- requirements
Module: pipeline_mem_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 15, maximum cycles a granted access waits for mem_ack before abort (legal 1..255).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 if_req  input  1  instruction-fetch read request, level, held until if_done.
REQ-005 if_addr  input  32  fetch address.
REQ-006 if_rdata  output  32  fetch data, valid while if_done=1.
REQ-007 if_done  output  1  fetch completion, one-cycle pulse.
REQ-008 dm_req  input  1  data-memory request, level, held until dm_done.
REQ-009 dm_we  input  1  data write enable (1=store, 0=load), MemRW encoding.
REQ-010 dm_addr  input  32  data address.
REQ-011 dm_wdata  input  32  store data.
REQ-012 dm_rdata  output  32  load data, valid while dm_done=1.
REQ-013 dm_done  output  1  data completion, one-cycle pulse.
REQ-014 mem_req  output  1  shared single-port memory request, registered.
REQ-015 mem_we  output  1  shared port write enable, registered.
REQ-016 mem_addr  output  32  shared port address, registered.
REQ-017 mem_wdata  output  32  shared port write data, registered.
REQ-018 mem_ack  input  1  memory completion, sampled only while mem_req=1.
REQ-019 mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-020 stall  output  1  pipeline freeze to Stall_ctrl: drives en_IF/en_IFID low.
REQ-021 err  output  1  sticky timeout flag.

Function
REQ-022 FSM states IDLE, IF_WAIT, DM_WAIT; one access outstanding at a time.
REQ-023 IDLE, only if_req: next state IF_WAIT; latch if_addr into mem_addr, mem_we=0, mem_req=1.
REQ-024 IDLE, only dm_req: next state DM_WAIT; latch dm_addr/dm_we/dm_wdata, mem_req=1.
REQ-025 IDLE, both requests: arbitration per REQ-036/037.
REQ-026 X_WAIT with mem_ack=1: X_done=1 same cycle, X_rdata=mem_rdata (combinational), next state IDLE, mem_req=0.
REQ-027 Minimum latency: request seen cycle 0, done cycle 1 (ack on first mem_req cycle); done never asserted in IDLE.
REQ-028 Latched mem_addr/mem_we/mem_wdata stable through entire WAIT; request input changes during WAIT ignored.
REQ-029 8-bit wait counter: cleared on grant, +1 each WAIT cycle without ack.
REQ-030 Counter equal MAX_WAIT without ack: abort -- X_done=1, X_rdata=0, err set, next state IDLE, mem_req=0.
REQ-031 Ack in same cycle as counter reaches MAX_WAIT: ack wins, no abort, err unchanged.
REQ-032 Non-granted done output 0; rdata of idle requester 0.
REQ-033 stall = (if_req & ~if_done) | (dm_req & ~dm_done); 0 while rst=1.
REQ-034 Back-to-back: request re-presented in cycle after done is granted in that IDLE cycle; no lost or duplicated access.

Reset
REQ-035 rst=1 immediately (no clock): state IDLE, mem_req/mem_we=0, mem_addr/mem_wdata=0, counter 0, err 0, last-grant=IF; access in flight discarded, no done pulse; mem_ack during reset ignored.

Configuration
REQ-036 Macro MEM_ARB_RR_EN defined: round-robin on tie -- grant requester not last granted; last-grant register updates on every grant.
REQ-037 MEM_ARB_RR_EN undefined: fixed priority, dm_req always wins ties (older instruction first); no last-grant register.

Verification
REQ-038 if_req=1, if_addr=0x00000010, mem_ack on 2nd WAIT cycle, mem_rdata=0x00A00093 -> mem_req 2 cycles, if_done pulse cycle 2, if_rdata=0x00A00093, stall 1 for cycles 0-1, 0 in cycle 2.
REQ-039 dm_req=1, dm_we=1, dm_addr=0x20, dm_wdata=0xDEADBEEF, ack immediate -> mem_we=1, mem_addr=0x20, mem_wdata=0xDEADBEEF, dm_done cycle 1.
REQ-040 if_req and dm_req both held for 4 accesses, ack immediate -> without macro DM,DM,DM,DM (IF starved while dm_req held); with MEM_ARB_RR_EN DM,IF,DM,IF.
REQ-041 MAX_WAIT=3, dm_req load, mem_ack never -> abort after 3 WAIT cycles, dm_done=1, dm_rdata=0, err=1 stays 1 until rst.
REQ-042 rst pulsed mid DM_WAIT -> mem_req=0 asynchronously, no dm_done, after release if_req granted first under either config.
